ay_audio_mixer: RTL and testbench
=================================

# ay_audio_mixer

Downstream audio stage for the AY sound block. It takes the 8-bit AY level plus the 1-bit beeper and tape-monitor signals and sums them into a saturated 10-bit sample. It applies a click-free gain ramp for power-up and mute, then drives a first-order sigma-delta modulator whose 1-bit output feeds the board's RC-filtered audio pin.

## Interface

Parameters:

- BEEP_LEVEL, 255: amplitude added when beeper=1; legal range 0..511.
- TAPE_LEVEL, 64: amplitude added when tape=1; legal range 0..511.
- RAMP_DIV, 1: number of ce pulses per gain step; legal range 1..16.

Ports:

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high. One clock; reset is asynchronous and active-high.
- ce  in  1  sample strobe, the same enable that clocks the AY core; one clk wide.
- ay_sound  in  8  unsigned AY mixer output.
- beeper  in  1  speaker bit.
- tape  in  1  tape-in monitor bit.
- mute  in  1  request fade-out to silence; level-sensitive.
- pcm_out  out  10  gained, mixed sample, unsigned.
- sdm_out  out  1  sigma-delta bitstream.
- fade_done  out  1  high while in state RUN (gain = 256).

## Operation

- Mix:
  - sum = ay_sound + (beeper ? BEEP_LEVEL : 0) + (tape ? TAPE_LEVEL : 0), computed 11 bits wide.
  - If sum > 1023, the result saturates to 1023.
  - The result is latched into mix_r (10 bits) on clk when ce=1 and held otherwise.
- Gain:
  - gain is a 9-bit register, 0..256.
  - A step counter counts ce pulses. One gain step is taken on the ce that completes RAMP_DIV pulses; the counter then clears.
  - The step counter clears on every state change.
- State machine (2 bits), transitions evaluated on ce only:
  - RAMP_UP:
    - On a step, gain += 1.
    - When gain reaches 256, go to RUN.
    - If mute=1, go to RAMP_DOWN; gain is unchanged that cycle.
  - RUN:
    - gain holds at 256.
    - If mute=1, go to RAMP_DOWN.
  - RAMP_DOWN:
    - On a step, gain -= 1.
    - When gain reaches 0, go to MUTED.
    - If mute=0, go to RAMP_UP from the current gain.
  - MUTED:
    - gain holds at 0.
    - If mute=0, go to RAMP_UP.
- Gain never wraps: no increment occurs at 256 and no decrement at 0.
- Gain multiply:
  - pcm_out <= (mix_r × gain) >> 8, registered every clk.
  - The 18-bit product is truncated; the result is at most 1023, so no overflow.
- Sigma-delta:
  - The 10-bit accumulator acc runs every clk, independent of ce.
  - s = acc + pcm_out (11 bits); acc <= s[9:0]; sdm_out <= s[10].
  - Long-run density of ones = pcm_out/1024.

## Timing

- Reset values: state=RAMP_UP, gain=0, step counter=0, mix_r=0, pcm_out=0, acc=0, sdm_out=0, fade_done=0.
- After reset deasserts, the gain ramp starts automatically; nothing needs to drive mute.
- Latency:
  - Inputs are sampled at the clk edge where ce=1 (edge N).
  - mix_r and gain update at edge N.
  - pcm_out reflects both at edge N+1.
  - sdm_out first reflects the new pcm_out at edge N+2.
- Inputs are ignored when ce=0, except by the SDM, which keeps integrating the held pcm_out.
- Full ramp length from gain 0 to 256 is 256×RAMP_DIV ce pulses.
- fade_done rises at the edge where gain becomes 256.
- If mute toggles on the same ce that would complete a ramp, the mute transition wins. Example: in RAMP_UP with gain=255 and mute=1, the next state is RAMP_DOWN and gain stays 255.
- An asynchronous reset mid-ramp or mid-sample returns all registers to their reset values immediately; no partial sample is emitted.
- Back-to-back ce (ce high on consecutive clocks) is legal; every ce is a sample.

## Test plan

- Reset: assert reset asynchronously mid-cycle with ay_sound=255 -> pcm_out=0, sdm_out=0, fade_done=0 within the same cycle; all remain 0 until ce arrives.
- Power-up ramp: RAMP_DIV=1, ay_sound=200, ce every 4 clk, mute=0 -> pcm_out increases monotonically; after the 256th ce, fade_done=1 and pcm_out=200 one clk later.
- Saturation: BEEP_LEVEL=511, TAPE_LEVEL=511, ay_sound=255, beeper=tape=1, in RUN -> pcm_out=1023; sdm_out has exactly 1023 ones per 1024 clocks.
- SDM density: in RUN with ay_sound=0, beeper=0, tape=1, TAPE_LEVEL=256 -> pcm_out=256; sdm_out is periodic with one 1 every 4 clocks, exactly 256 ones per 1024 clocks.
- Mute mid-ramp:
  - After 100 ce in RAMP_UP, assert mute -> gain falls 100→0 over 100 ce, state MUTED, pcm_out=0, fade_done=0.
  - Deassert mute -> the ramp restarts from 0.
- Simultaneous events: with gain=255 in RAMP_UP, assert mute on the completing ce -> gain stays 255, fade_done stays 0, and the next ce yields gain=254.

Source files
------------

// File: rtl/ay_audio_mixer.sv
// AY audio output stage: mixes AY level, beeper and tape monitor into a saturated
// 10-bit sample, applies a click-free gain ramp and drives a 1-bit sigma-delta DAC.
module ay_audio_mixer #(
    parameter int BEEP_LEVEL = 255,
    parameter int TAPE_LEVEL = 64,
    parameter int RAMP_DIV   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] ay_sound,
    input  logic       beeper,
    input  logic       tape,
    input  logic       mute,
    output logic [9:0] pcm_out,
    output logic       sdm_out,
    output logic       fade_done
);

    typedef enum logic [1:0] {
        RAMP_UP   = 2'd0,
        RUN       = 2'd1,
        RAMP_DOWN = 2'd2,
        MUTED     = 2'd3
    } state_t;

    localparam logic [3:0]  STEP_LAST = 4'(RAMP_DIV - 1);
    localparam logic [8:0]  GAIN_MAX  = 9'd256;
    localparam logic [10:0] BEEP_AMP  = 11'(BEEP_LEVEL);
    localparam logic [10:0] TAPE_AMP  = 11'(TAPE_LEVEL);

    state_t      state_q, state_d;
    logic [8:0]  gain_q, gain_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  mix_q, mix_d;
    logic [9:0]  pcm_q, pcm_d;
    logic [9:0]  acc_q, acc_d;
    logic        sdm_q, sdm_d;
    logic        fade_q, fade_d;

    logic [10:0] sum;
    logic [17:0] prod;
    logic [10:0] sdm_sum;
    logic        step;

    always_comb begin
        sum = {3'b000, ay_sound} + (beeper ? BEEP_AMP : 11'd0) + (tape ? TAPE_AMP : 11'd0);
        mix_d = mix_q;
        if (ce) begin
            mix_d = (sum > 11'd1023) ? 10'h3ff : sum[9:0];
        end
    end

    // Gain ramp FSM. A mute change always takes priority over a gain step on the same ce.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        cnt_d   = cnt_q;
        step    = (cnt_q == STEP_LAST);
        if (ce) begin
            cnt_d = step ? 4'd0 : cnt_q + 4'd1;
            case (state_q)
                RAMP_UP: begin
                    if (mute) begin
                        state_d = RAMP_DOWN;
                    end else if (gain_q == GAIN_MAX) begin
                        state_d = RUN;
                    end else if (step) begin
                        gain_d = gain_q + 9'd1;
                        if (gain_q == GAIN_MAX - 9'd1) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (mute) begin
                        state_d = RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (!mute) begin
                        state_d = RAMP_UP;
                    end else if (gain_q == 9'd0) begin
                        state_d = MUTED;
                    end else if (step) begin
                        gain_d = gain_q - 9'd1;
                        if (gain_q == 9'd1) begin
                            state_d = MUTED;
                        end
                    end
                end
                default: begin
                    if (!mute) begin
                        state_d = RAMP_UP;
                    end
                end
            endcase
            if (state_d != state_q) begin
                cnt_d = 4'd0;
            end
        end
    end

    // Product of 10-bit mix and gain <= 256 always fits in 18 bits.
    always_comb begin
        prod    = {8'd0, mix_q} * {9'd0, gain_q};
        pcm_d   = prod[17:8];
        sdm_sum = {1'b0, acc_q} + {1'b0, pcm_q};
        acc_d   = sdm_sum[9:0];
        sdm_d   = sdm_sum[10];
        fade_d  = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RAMP_UP;
            gain_q  <= 9'd0;
            cnt_q   <= 4'd0;
            mix_q   <= 10'd0;
            pcm_q   <= 10'd0;
            acc_q   <= 10'd0;
            sdm_q   <= 1'b0;
            fade_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            cnt_q   <= cnt_d;
            mix_q   <= mix_d;
            pcm_q   <= pcm_d;
            acc_q   <= acc_d;
            sdm_q   <= sdm_d;
            fade_q  <= fade_d;
        end
    end

    assign pcm_out   = pcm_q;
    assign sdm_out   = sdm_q;
    assign fade_done = fade_q;

endmodule

// File: tb/tb_ay_audio_mixer.sv
// Directed bench for ay_audio_mixer: four instances with different levels/ramp
// divider share one stimulus stream; expected values are worked out by hand.
module tb_ay_audio_mixer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic [7:0] ay_sound;
    logic       beeper;
    logic       tape;
    logic       mute;

    logic [9:0] pcm_a, pcm_b, pcm_c, pcm_d;
    logic       sdm_a, sdm_b, sdm_c, sdm_d;
    logic       fade_a, fade_b, fade_c, fade_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ay_audio_mixer u_dut_a (
        .clk(clk), .reset(reset), .ce(ce), .ay_sound(ay_sound), .beeper(beeper),
        .tape(tape), .mute(mute), .pcm_out(pcm_a), .sdm_out(sdm_a), .fade_done(fade_a)
    );

    ay_audio_mixer #(.BEEP_LEVEL(511), .TAPE_LEVEL(511), .RAMP_DIV(1)) u_dut_b (
        .clk(clk), .reset(reset), .ce(ce), .ay_sound(ay_sound), .beeper(beeper),
        .tape(tape), .mute(mute), .pcm_out(pcm_b), .sdm_out(sdm_b), .fade_done(fade_b)
    );

    ay_audio_mixer #(.BEEP_LEVEL(255), .TAPE_LEVEL(256), .RAMP_DIV(1)) u_dut_c (
        .clk(clk), .reset(reset), .ce(ce), .ay_sound(ay_sound), .beeper(beeper),
        .tape(tape), .mute(mute), .pcm_out(pcm_c), .sdm_out(sdm_c), .fade_done(fade_c)
    );

    ay_audio_mixer #(.BEEP_LEVEL(255), .TAPE_LEVEL(64), .RAMP_DIV(3)) u_dut_d (
        .clk(clk), .reset(reset), .ce(ce), .ay_sound(ay_sound), .beeper(beeper),
        .tape(tape), .mute(mute), .pcm_out(pcm_d), .sdm_out(sdm_d), .fade_done(fade_d)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Hold ce high for n consecutive clocks, then wait one clock so pcm_out reflects the last ce.
    task automatic ce_burst(input int n);
        ce = 1'b1;
        repeat (n) @(negedge clk);
        ce = 1'b0;
        @(negedge clk);
    endtask

    task automatic count_ones(output int ones_a, output int ones_b, output int ones_c);
        ones_a = 0;
        ones_b = 0;
        ones_c = 0;
        for (int i = 0; i < 1024; i++) begin
            ones_a += int'(sdm_a);
            ones_b += int'(sdm_b);
            ones_c += int'(sdm_c);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int oa, ob, oc;
        reset    = 1'b1;
        ce       = 1'b0;
        ay_sound = 8'd255;
        beeper   = 1'b0;
        tape     = 1'b0;
        mute     = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_pcm", pcm_a, 0);
        check_eq("reset_sdm", sdm_a, 0);
        check_eq("reset_fade", fade_a, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("idle_pcm", pcm_a, 0);
        check_eq("idle_sdm", sdm_a, 0);
        $display("[TB] reset and idle checked");

        // Power-up ramp, one ce every 4 clocks.
        ay_sound = 8'd200;
        for (int k = 1; k <= 255; k++) begin
            ce_burst(1);
            check_eq($sformatf("ramp_a_%0d", k), pcm_a, (200 * k) >> 8);
            check_eq($sformatf("ramp_d_%0d", k), pcm_d, (200 * (k / 3)) >> 8);
            repeat (2) @(negedge clk);
        end
        check_eq("ramp_fade_255", fade_a, 0);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        check_eq("ramp_fade_256", fade_a, 1);
        check_eq("ramp_pcm_edgeN", pcm_a, 199);
        @(negedge clk);
        check_eq("ramp_pcm_full", pcm_a, 200);
        check_eq("ramp_fade_b", fade_b, 1);
        $display("[TB] power-up ramp checked, pcm=%0d", pcm_a);

        // Saturation in RUN.
        ay_sound = 8'd255;
        beeper   = 1'b1;
        tape     = 1'b1;
        ce_burst(1);
        check_eq("sat_pcm_b", pcm_b, 1023);
        check_eq("mix_pcm_a", pcm_a, 574);
        check_eq("mix_pcm_c", pcm_c, 766);
        @(negedge clk);
        count_ones(oa, ob, oc);
        check_eq("sat_ones_b", ob, 1023);
        check_eq("mix_ones_a", oa, 574);
        $display("[TB] saturation: pcm_b=%0d ones_b=%0d", pcm_b, ob);

        // Sigma-delta density.
        ay_sound = 8'd0;
        beeper   = 1'b0;
        tape     = 1'b1;
        ce_burst(1);
        check_eq("sdm_pcm_c", pcm_c, 256);
        check_eq("sdm_pcm_a", pcm_a, 64);
        @(negedge clk);
        count_ones(oa, ob, oc);
        check_eq("sdm_ones_c", oc, 256);
        check_eq("sdm_ones_a", oa, 64);
        $display("[TB] sdm density: ones_c=%0d ones_a=%0d", oc, oa);

        // Fade out from RUN, then restart and mute mid-ramp.
        ay_sound = 8'd200;
        tape     = 1'b0;
        mute     = 1'b1;
        ce_burst(1);
        check_eq("mute_enter_pcm", pcm_a, 200);
        check_eq("mute_enter_fade", fade_a, 0);
        ce_burst(128);
        check_eq("mute_half_pcm", pcm_a, 100);
        ce_burst(128);
        check_eq("mute_zero_pcm", pcm_a, 0);
        ce_burst(5);
        check_eq("muted_hold_pcm", pcm_a, 0);
        check_eq("muted_fade", fade_a, 0);
        mute = 1'b0;
        ce_burst(1);
        check_eq("unmute_pcm", pcm_a, 0);
        ce_burst(2);
        check_eq("restart_pcm_2", pcm_a, 1);
        ce_burst(98);
        check_eq("up100_pcm", pcm_a, 78);
        mute = 1'b1;
        ce_burst(1);
        check_eq("down_enter_pcm", pcm_a, 78);
        ce_burst(50);
        check_eq("down50_pcm", pcm_a, 39);
        ce_burst(50);
        check_eq("down0_pcm", pcm_a, 0);
        check_eq("down0_fade", fade_a, 0);
        ce_burst(3);
        check_eq("muted2_pcm", pcm_a, 0);
        $display("[TB] mute mid-ramp checked");

        // Mute arriving on the ce that would complete the ramp.
        mute = 1'b0;
        ce_burst(1);
        ce_burst(255);
        check_eq("g255_pcm", pcm_a, 199);
        check_eq("g255_fade", fade_a, 0);
        mute = 1'b1;
        ce_burst(1);
        check_eq("simul_pcm", pcm_a, 199);
        check_eq("simul_fade", fade_a, 0);
        ce_burst(1);
        check_eq("simul_next_pcm", pcm_a, 198);
        check_eq("simul_next_fade", fade_a, 0);
        $display("[TB] simultaneous mute/complete checked");

        // Asynchronous reset mid-cycle.
        ay_sound = 8'd255;
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_pcm", pcm_a, 0);
        check_eq("async_sdm", sdm_a, 0);
        check_eq("async_fade", fade_a, 0);
        check_eq("async_pcm_b", pcm_b, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_reset_pcm", pcm_a, 0);
        check_eq("post_reset_sdm", sdm_a, 0);
        $display("[TB] async reset checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
